// File: rtl/register_file_pkg.sv
// Shared widths and types for the RISC-V integer register file.
package register_file_pkg;
  localparam int DATA_WIDTH   = 32;
  localparam int NUM_REGS     = 32;
  localparam int ADDR_WIDTH   = 5;
  localparam int NUM_RD_PORTS = 2;

  typedef logic [ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [DATA_WIDTH-1:0] reg_data_t;
endpackage

// File: rtl/register_file_intf.sv
// Bundle of all register file ports, with a driver clocking block and a passive monitor view.
interface register_file_intf
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH = register_file_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = register_file_pkg::ADDR_WIDTH
) (
  input logic clk
);
  logic                  rst;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_reg;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [ADDR_WIDTH-1:0] rd_reg_1;
  logic [ADDR_WIDTH-1:0] rd_reg_2;
  logic [DATA_WIDTH-1:0] rd_data_1;
  logic [DATA_WIDTH-1:0] rd_data_2;

  clocking cb_drive @(posedge clk);
    output wr_en, wr_reg, wr_data, rd_reg_1, rd_reg_2;
    input  rd_data_1, rd_data_2;
  endclocking

  modport dut (
    input  clk, rst, wr_en, wr_reg, wr_data, rd_reg_1, rd_reg_2,
    output rd_data_1, rd_data_2
  );

  modport monitor (
    input clk, rst, wr_en, wr_reg, wr_data, rd_reg_1, rd_reg_2, rd_data_1, rd_data_2
  );
endinterface

// File: rtl/register_file_assert.sv
// Bound checker over the monitor view: x0 reads zero, and everything reads zero right after reset.
module register_file_assert
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH = register_file_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = register_file_pkg::ADDR_WIDTH
) (
  input logic                  clk,
  input logic                  rst,
  input logic [ADDR_WIDTH-1:0] rd_reg_1,
  input logic [ADDR_WIDTH-1:0] rd_reg_2,
  input logic [DATA_WIDTH-1:0] rd_data_1,
  input logic [DATA_WIDTH-1:0] rd_data_2
);
  a_x0_port1: assert property (@(posedge clk) (rd_reg_1 == '0) |-> (rd_data_1 == '0));
  a_x0_port2: assert property (@(posedge clk) (rd_reg_2 == '0) |-> (rd_data_2 == '0));

  // Any write after reset only lands on the following edge, so the next cycle reads all zero.
  a_rst_clear: assert property (@(posedge clk) rst |=> ((rd_data_1 == '0) && (rd_data_2 == '0)));
endmodule

bind register_file register_file_assert #(
  .DATA_WIDTH (DATA_WIDTH),
  .ADDR_WIDTH (ADDR_WIDTH)
) u_assert (
  .clk       (clk),
  .rst       (rst),
  .rd_reg_1  (rd_reg_1),
  .rd_reg_2  (rd_reg_2),
  .rd_data_1 (rd_data_1),
  .rd_data_2 (rd_data_2)
);

// File: rtl/register_file_read_port.sv
// One combinational read port: selects a register, x0 hard-wired to zero.
module reg_read_port
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH = register_file_pkg::DATA_WIDTH,
  parameter int NUM_REGS   = register_file_pkg::NUM_REGS,
  parameter int ADDR_WIDTH = register_file_pkg::ADDR_WIDTH
) (
  input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs,
  input  logic [ADDR_WIDTH-1:0]               rd_reg,
  output logic [DATA_WIDTH-1:0]               rd_data
);
  // x0 is forced here so it reads zero even before the first reset.
  always_comb begin
    rd_data = regs[rd_reg];
    if (rd_reg == '0) rd_data = '0;
  end
endmodule

// File: rtl/register_file.sv
// RISC-V integer register file: 2 combinational read ports, 1 synchronous write port.
module register_file
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH = register_file_pkg::DATA_WIDTH,
  parameter int NUM_REGS   = register_file_pkg::NUM_REGS,
  parameter int ADDR_WIDTH = register_file_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_reg,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_reg_1,
  input  logic [ADDR_WIDTH-1:0] rd_reg_2,
  output logic [DATA_WIDTH-1:0] rd_data_1,
  output logic [DATA_WIDTH-1:0] rd_data_2
);
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0]     regs;
  logic [NUM_RD_PORTS-1:0][ADDR_WIDTH-1:0] rd_reg;
  logic [NUM_RD_PORTS-1:0][DATA_WIDTH-1:0] rd_data;

  // Reset beats a coincident write; writes to x0 are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs <= '0;
    end else if (wr_en && (wr_reg != '0)) begin
      regs[wr_reg] <= wr_data;
    end
  end

  assign rd_reg = {rd_reg_2, rd_reg_1};

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
    reg_read_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_REGS   (NUM_REGS),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_rd (
      .regs    (regs),
      .rd_reg  (rd_reg[p]),
      .rd_data (rd_data[p])
    );
  end

  assign rd_data_1 = rd_data[0];
  assign rd_data_2 = rd_data[1];
endmodule

// File: tb/tb_register_file.sv
// Scoreboarded bench for register_file: directed tables plus a random run against a read-before-write model.
module tb_register_file;
  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [4:0]  wr_reg;
  logic [31:0] wr_data;
  logic [4:0]  rd_reg_1;
  logic [4:0]  rd_reg_2;
  logic [31:0] rd_data_1;
  logic [31:0] rd_data_2;

  logic [31:0] model [32];
  logic [31:0] exp_q [$];
  int n_pass;
  int n_total;

  typedef struct {
    logic        r;
    logic        we;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] e1;
    logic [31:0] e2;
  } step_t;

  register_file #(
    .DATA_WIDTH (32),
    .NUM_REGS   (32),
    .ADDR_WIDTH (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_reg    (wr_reg),
    .wr_data   (wr_data),
    .rd_reg_1  (rd_reg_1),
    .rd_reg_2  (rd_reg_2),
    .rd_data_1 (rd_data_1),
    .rd_data_2 (rd_data_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs change on the falling edge; the model commits what the next rising edge will do.
  task automatic drive(input logic r, input logic we, input logic [4:0] wr, input logic [31:0] wd,
                       input logic [4:0] r1, input logic [4:0] r2);
    @(negedge clk);
    rst = r; wr_en = we; wr_reg = wr; wr_data = wd; rd_reg_1 = r1; rd_reg_2 = r2;
    if (r) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (we && (wr != 5'd0)) begin
      model[wr] = wd;
    end
  endtask

  task automatic test_reset();
    step_t s[3];
    logic [31:0] e;
    s = '{
      '{1'b1, 1'b1, 5'd7, 32'hFFFFFFFF, 5'd0, 5'd0,  32'h0, 32'h0},
      '{1'b0, 1'b0, 5'd0, 32'h0,        5'd0, 5'd0,  32'h0, 32'h0},
      '{1'b0, 1'b0, 5'd0, 32'h0,        5'd7, 5'd31, 32'h0, 32'h0}
    };
    foreach (s[i]) begin
      exp_q.push_back(s[i].e1); exp_q.push_back(s[i].e2);
      drive(s[i].r, s[i].we, s[i].wr, s[i].wd, s[i].r1, s[i].r2);
      #1;
      e = exp_q.pop_front(); n_total++;
      if (rd_data_1 !== e) $display("FAIL reset[%0d] rd_data_1 got %h expected %h", i, rd_data_1, e);
      else n_pass++;
      e = exp_q.pop_front(); n_total++;
      if (rd_data_2 !== e) $display("FAIL reset[%0d] rd_data_2 got %h expected %h", i, rd_data_2, e);
      else n_pass++;
    end
  endtask

  task automatic test_write_visibility();
    step_t s[2];
    logic [31:0] e;
    s = '{
      '{1'b0, 1'b1, 5'd5, 32'hFFFF0000, 5'd5, 5'd5, 32'h0,        32'h0},
      '{1'b0, 1'b0, 5'd0, 32'h0,        5'd5, 5'd0, 32'hFFFF0000, 32'h0}
    };
    foreach (s[i]) begin
      exp_q.push_back(s[i].e1); exp_q.push_back(s[i].e2);
      drive(s[i].r, s[i].we, s[i].wr, s[i].wd, s[i].r1, s[i].r2);
      #1;
      e = exp_q.pop_front(); n_total++;
      if (rd_data_1 !== e) $display("FAIL write_vis[%0d] rd_data_1 got %h expected %h", i, rd_data_1, e);
      else n_pass++;
      e = exp_q.pop_front(); n_total++;
      if (rd_data_2 !== e) $display("FAIL write_vis[%0d] rd_data_2 got %h expected %h", i, rd_data_2, e);
      else n_pass++;
    end
  endtask

  task automatic test_overwrite();
    step_t s[3];
    logic [31:0] e;
    s = '{
      '{1'b0, 1'b1, 5'd15, 32'hFFFF0000, 5'd15, 5'd15, 32'h0,        32'h0},
      '{1'b0, 1'b1, 5'd15, 32'h0000FFFF, 5'd5,  5'd15, 32'hFFFF0000, 32'hFFFF0000},
      '{1'b0, 1'b0, 5'd0,  32'h0,        5'd5,  5'd15, 32'hFFFF0000, 32'h0000FFFF}
    };
    foreach (s[i]) begin
      exp_q.push_back(s[i].e1); exp_q.push_back(s[i].e2);
      drive(s[i].r, s[i].we, s[i].wr, s[i].wd, s[i].r1, s[i].r2);
      #1;
      e = exp_q.pop_front(); n_total++;
      if (rd_data_1 !== e) $display("FAIL overwrite[%0d] rd_data_1 got %h expected %h", i, rd_data_1, e);
      else n_pass++;
      e = exp_q.pop_front(); n_total++;
      if (rd_data_2 !== e) $display("FAIL overwrite[%0d] rd_data_2 got %h expected %h", i, rd_data_2, e);
      else n_pass++;
    end
  endtask

  task automatic test_x0_write();
    step_t s[3];
    logic [31:0] e;
    s = '{
      '{1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0,  32'h0,        32'h0},
      '{1'b0, 1'b0, 5'd0, 32'h0,        5'd0, 5'd0,  32'h0,        32'h0},
      '{1'b0, 1'b0, 5'd0, 32'h0,        5'd5, 5'd15, 32'hFFFF0000, 32'h0000FFFF}
    };
    foreach (s[i]) begin
      exp_q.push_back(s[i].e1); exp_q.push_back(s[i].e2);
      drive(s[i].r, s[i].we, s[i].wr, s[i].wd, s[i].r1, s[i].r2);
      #1;
      e = exp_q.pop_front(); n_total++;
      if (rd_data_1 !== e) $display("FAIL x0_write[%0d] rd_data_1 got %h expected %h", i, rd_data_1, e);
      else n_pass++;
      e = exp_q.pop_front(); n_total++;
      if (rd_data_2 !== e) $display("FAIL x0_write[%0d] rd_data_2 got %h expected %h", i, rd_data_2, e);
      else n_pass++;
    end
  endtask

  task automatic test_hold();
    step_t s[6];
    logic [31:0] e;
    s = '{
      '{1'b0, 1'b1, 5'd20, 32'hFFFFFFFF, 5'd20, 5'd20, 32'h0,        32'h0},
      '{1'b0, 1'b0, 5'd20, 32'h0,        5'd20, 5'd20, 32'hFFFFFFFF, 32'hFFFFFFFF},
      '{1'b0, 1'b0, 5'd20, 32'h0,        5'd20, 5'd20, 32'hFFFFFFFF, 32'hFFFFFFFF},
      '{1'b0, 1'b0, 5'd20, 32'h0,        5'd20, 5'd20, 32'hFFFFFFFF, 32'hFFFFFFFF},
      '{1'b0, 1'b1, 5'd20, 32'h0,        5'd20, 5'd20, 32'hFFFFFFFF, 32'hFFFFFFFF},
      '{1'b0, 1'b0, 5'd0,  32'h0,        5'd20, 5'd20, 32'h0,        32'h0}
    };
    foreach (s[i]) begin
      exp_q.push_back(s[i].e1); exp_q.push_back(s[i].e2);
      drive(s[i].r, s[i].we, s[i].wr, s[i].wd, s[i].r1, s[i].r2);
      #1;
      e = exp_q.pop_front(); n_total++;
      if (rd_data_1 !== e) $display("FAIL hold[%0d] rd_data_1 got %h expected %h", i, rd_data_1, e);
      else n_pass++;
      e = exp_q.pop_front(); n_total++;
      if (rd_data_2 !== e) $display("FAIL hold[%0d] rd_data_2 got %h expected %h", i, rd_data_2, e);
      else n_pass++;
    end
  endtask

  task automatic test_same_reg();
    step_t s[3];
    logic [31:0] e;
    s = '{
      '{1'b0, 1'b1, 5'd31, 32'hA5A55A5A, 5'd31, 5'd31, 32'h0,        32'h0},
      '{1'b0, 1'b1, 5'd1,  32'h00000001, 5'd31, 5'd1,  32'hA5A55A5A, 32'h0},
      '{1'b0, 1'b0, 5'd1,  32'h0,        5'd1,  5'd31, 32'h00000001, 32'hA5A55A5A}
    };
    foreach (s[i]) begin
      exp_q.push_back(s[i].e1); exp_q.push_back(s[i].e2);
      drive(s[i].r, s[i].we, s[i].wr, s[i].wd, s[i].r1, s[i].r2);
      #1;
      e = exp_q.pop_front(); n_total++;
      if (rd_data_1 !== e) $display("FAIL same_reg[%0d] rd_data_1 got %h expected %h", i, rd_data_1, e);
      else n_pass++;
      e = exp_q.pop_front(); n_total++;
      if (rd_data_2 !== e) $display("FAIL same_reg[%0d] rd_data_2 got %h expected %h", i, rd_data_2, e);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic        we;
    logic [4:0]  wr, r1, r2;
    logic [31:0] wd, e;
    int          sel;
    for (int i = 0; i < 1000; i++) begin
      we  = 1'($urandom_range(0, 1));
      wr  = 5'($urandom_range(0, 31));
      r1  = 5'($urandom_range(0, 31));
      r2  = (i % 7 == 0) ? wr : 5'($urandom_range(0, 31));
      sel = $urandom_range(0, 9);
      wd  = (sel == 0) ? 32'h0 : (sel == 1) ? 32'hFFFFFFFF : $urandom;
      exp_q.push_back((r1 == 5'd0) ? 32'h0 : model[r1]);
      exp_q.push_back((r2 == 5'd0) ? 32'h0 : model[r2]);
      drive(1'b0, we, wr, wd, r1, r2);
      #1;
      e = exp_q.pop_front(); n_total++;
      if (rd_data_1 !== e) $display("FAIL random[%0d] rd_data_1 x%0d got %h expected %h", i, r1, rd_data_1, e);
      else n_pass++;
      e = exp_q.pop_front(); n_total++;
      if (rd_data_2 !== e) $display("FAIL random[%0d] rd_data_2 x%0d got %h expected %h", i, r2, rd_data_2, e);
      else n_pass++;
    end
  endtask

  task automatic test_reset_clears();
    step_t s[3];
    logic [31:0] e;
    drive(1'b1, 1'b1, 5'd9, 32'h12345678, 5'd0, 5'd0);
    s = '{
      '{1'b0, 1'b0, 5'd0, 32'h0, 5'd9,  5'd31, 32'h0, 32'h0},
      '{1'b0, 1'b0, 5'd0, 32'h0, 5'd5,  5'd15, 32'h0, 32'h0},
      '{1'b0, 1'b0, 5'd0, 32'h0, 5'd20, 5'd1,  32'h0, 32'h0}
    };
    foreach (s[i]) begin
      exp_q.push_back(s[i].e1); exp_q.push_back(s[i].e2);
      drive(s[i].r, s[i].we, s[i].wr, s[i].wd, s[i].r1, s[i].r2);
      #1;
      e = exp_q.pop_front(); n_total++;
      if (rd_data_1 !== e) $display("FAIL reset_clears[%0d] rd_data_1 got %h expected %h", i, rd_data_1, e);
      else n_pass++;
      e = exp_q.pop_front(); n_total++;
      if (rd_data_2 !== e) $display("FAIL reset_clears[%0d] rd_data_2 got %h expected %h", i, rd_data_2, e);
      else n_pass++;
    end
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    rst = 1'b0; wr_en = 1'b0; wr_reg = 5'd0; wr_data = 32'h0; rd_reg_1 = 5'd0; rd_reg_2 = 5'd0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    test_reset();
    test_write_visibility();
    test_overwrite();
    test_x0_write();
    test_hold();
    test_same_reg();
    test_random();
    test_reset_clears();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
